// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram_controller between two requesters and routes each read response to its issuer.
// Build option: define SRAM_ARB_FIXED_PRIORITY_EN for fixed priority (port 0 always wins); default is round-robin.
module sram_arbiter #(
    parameter int ADDR_WIDTH      = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_rw,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_gnt,
    input  logic                  req1_valid,
    input  logic                  req1_rw,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_gnt,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  memctrl_enable,
    output logic                  memctrl_rw,
    output logic [ADDR_WIDTH-1:0] memctrl_addr,
    output logic [DATA_WIDTH-1:0] memctrl_write_data,
    input  logic                  dat_ready,
    input  logic [DATA_WIDTH-1:0] memctrl_out_data,
    output logic                  arb_err
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0]           outstanding_r;
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [MAX_OUTSTANDING-1:0] tag_fifo_r;
    logic                       mem_en_r;
    logic                       mem_rw_r;
    logic [ADDR_WIDTH-1:0]      mem_addr_r;
    logic [DATA_WIDTH-1:0]      mem_wdata_r;
    logic                       rsp0_valid_r;
    logic                       rsp1_valid_r;
    logic [DATA_WIDTH-1:0]      rsp0_data_r;
    logic [DATA_WIDTH-1:0]      rsp1_data_r;
    logic                       arb_err_r;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
    logic                       last_winner_r;
`endif

    logic                  elig0_s;
    logic                  elig1_s;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  grant_s;
    logic                  win_rw_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [DATA_WIDTH-1:0] win_wdata_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  err_s;
    logic                  head_tag_s;

    // Reads need a free tag slot; writes never produce a response so they are always eligible.
    assign elig0_s    = req0_valid & (req0_rw | (outstanding_r < CNT_MAX));
    assign elig1_s    = req1_valid & (req1_rw | (outstanding_r < CNT_MAX));
    assign grant_s    = gnt0_s | gnt1_s;
    assign push_s     = grant_s & ~win_rw_s;
    assign pop_s      = dat_ready & (outstanding_r != CNT_ZERO);
    assign err_s      = dat_ready & (outstanding_r == CNT_ZERO);
    assign head_tag_s = tag_fifo_r[rd_ptr_r];

    // Arbitration between the two eligible requesters
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        end else if (elig0_s) begin
            gnt0_s = 1'b1;
`else
        end else if (elig0_s && elig1_s) begin
            if (last_winner_r) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (elig0_s) begin
            gnt0_s = 1'b1;
`endif
        end else if (elig1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Select the winning requester's command fields
    always_comb begin
        win_rw_s    = req0_rw;
        win_addr_s  = req0_addr;
        win_wdata_s = req0_wdata;
        if (gnt1_s) begin
            win_rw_s    = req1_rw;
            win_addr_s  = req1_addr;
            win_wdata_s = req1_wdata;
        end else begin
            win_rw_s    = req0_rw;
            win_addr_s  = req0_addr;
            win_wdata_s = req0_wdata;
        end
    end

    // Command register towards sram_controller; fields hold when idle
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_en_r    <= 1'b0;
            mem_rw_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            mem_en_r <= grant_s;
            if (grant_s) begin
                mem_rw_r    <= win_rw_s;
                mem_addr_r  <= win_addr_s;
                mem_wdata_r <= win_wdata_s;
            end
        end
    end

    // Read-tag FIFO and outstanding-read counter
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_fifo_r    <= {MAX_OUTSTANDING{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            outstanding_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                tag_fifo_r[wr_ptr_r] <= gnt1_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Route returned read data to the port named by the head tag; stray strobes set the sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_data_r  <= {DATA_WIDTH{1'b0}};
            rsp1_data_r  <= {DATA_WIDTH{1'b0}};
            arb_err_r    <= 1'b0;
        end else begin
            rsp0_valid_r <= pop_s & ~head_tag_s;
            rsp1_valid_r <= pop_s & head_tag_s;
            if (pop_s && !head_tag_s) begin
                rsp0_data_r <= memctrl_out_data;
            end
            if (pop_s && head_tag_s) begin
                rsp1_data_r <= memctrl_out_data;
            end
            if (err_s) begin
                arb_err_r <= 1'b1;
            end
        end
    end

`ifndef SRAM_ARB_FIXED_PRIORITY_EN
    // Remember the last granted port so ties alternate
    always_ff @(posedge clock) begin
        if (reset) begin
            last_winner_r <= 1'b1;
        end else if (grant_s) begin
            last_winner_r <= gnt1_s;
        end
    end
`endif

    assign req0_gnt           = gnt0_s;
    assign req1_gnt           = gnt1_s;
    assign memctrl_enable     = mem_en_r;
    assign memctrl_rw         = mem_rw_r;
    assign memctrl_addr       = mem_addr_r;
    assign memctrl_write_data = mem_wdata_r;
    assign rsp0_valid         = rsp0_valid_r;
    assign rsp1_valid         = rsp1_valid_r;
    assign rsp0_data          = rsp0_data_r;
    assign rsp1_data          = rsp1_data_r;
    assign arb_err            = arb_err_r;
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: the bench plays both requesters and an in-order sram_controller,
// and checks every output against a queue-based reference model of the arbitration and tag rules.
module tb_sram_arbiter;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int MO = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valid, req0_rw, req1_valid, req1_rw;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_gnt, req1_gnt;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          memctrl_enable, memctrl_rw;
    logic [AW-1:0] memctrl_addr;
    logic [DW-1:0] memctrl_write_data;
    logic          dat_ready;
    logic [DW-1:0] memctrl_out_data;
    logic          arb_err;

    always #5 clock = ~clock;

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_gnt(req0_gnt),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_gnt(req1_gnt),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .memctrl_enable(memctrl_enable), .memctrl_rw(memctrl_rw), .memctrl_addr(memctrl_addr),
        .memctrl_write_data(memctrl_write_data), .dat_ready(dat_ready), .memctrl_out_data(memctrl_out_data),
        .arb_err(arb_err)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [8];
    rd_t           exp_q [$];
    int            last_win;
    logic          exp_en, exp_rw, exp_v0, exp_v1, exp_err;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_d0, exp_d1;

    // Controller model state (fed only by the DUT command outputs)
    logic [DW-1:0] ctl_mem [8];
    logic [DW-1:0] ctl_q [$];

    // Stimulus knobs
    int   p_req, p_wr, p_rdy;
    bit   force_err;
    bit   drop0, drop1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ctl_q.delete();
        last_win  = 1;
        exp_en    = 1'b0; exp_rw = 1'b0; exp_addr = '0; exp_wdata = '0;
        exp_v0    = 1'b0; exp_v1 = 1'b0; exp_d0 = '0; exp_d1 = '0;
        exp_err   = 1'b0;
        drop0     = 1'b0; drop1 = 1'b0;
    endtask

    task automatic cycle(input bit rst);
        bit  e0, e1, g0, g1;
        int  outs;
        rd_t r;
        @(negedge clock);
        check_eq("memctrl_enable", memctrl_enable, exp_en);
        check_eq("memctrl_rw", memctrl_rw, exp_rw);
        check_eq("memctrl_addr", memctrl_addr, exp_addr);
        check_eq("memctrl_write_data", memctrl_write_data, exp_wdata);
        check_eq("rsp0_valid", rsp0_valid, exp_v0);
        check_eq("rsp0_data", rsp0_data, exp_d0);
        check_eq("rsp1_valid", rsp1_valid, exp_v1);
        check_eq("rsp1_data", rsp1_data, exp_d1);
        check_eq("arb_err", arb_err, exp_err);

        reset = rst;
        if (memctrl_enable) begin
            if (memctrl_rw) ctl_mem[memctrl_addr] = memctrl_write_data;
            else            ctl_q.push_back(ctl_mem[memctrl_addr]);
        end
        dat_ready        = 1'b0;
        memctrl_out_data = $urandom;
        if (force_err) begin
            dat_ready = 1'b1;
        end else if (ctl_q.size() > 0 && ($urandom % 100) < p_rdy) begin
            dat_ready        = 1'b1;
            memctrl_out_data = ctl_q.pop_front();
        end

        if (drop0) begin req0_valid = 1'b0; drop0 = 1'b0; end
        if (drop1) begin req1_valid = 1'b0; drop1 = 1'b0; end
        if (!req0_valid && ($urandom % 100) < p_req) begin
            req0_valid = 1'b1; req0_rw = (($urandom % 100) < p_wr);
            req0_addr = AW'($urandom); req0_wdata = $urandom;
        end
        if (!req1_valid && ($urandom % 100) < p_req) begin
            req1_valid = 1'b1; req1_rw = (($urandom % 100) < p_wr);
            req1_addr = AW'($urandom); req1_wdata = $urandom;
        end
        #1;

        outs = exp_q.size();
        e0 = req0_valid && (req0_rw || outs < MO);
        e1 = req1_valid && (req1_rw || outs < MO);
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        g0 = e0;
        g1 = e1 && !e0;
`else
        if (e0 && e1) begin
            g0 = (last_win == 1);
            g1 = !g0;
        end else begin
            g0 = e0;
            g1 = e1;
        end
`endif
        if (rst) begin g0 = 1'b0; g1 = 1'b0; end
        check_eq("req0_gnt", req0_gnt, g0);
        check_eq("req1_gnt", req1_gnt, g1);

        if (rst) begin
            model_reset();
        end else begin
            exp_v0 = 1'b0;
            exp_v1 = 1'b0;
            if (dat_ready) begin
                if (exp_q.size() == 0) begin
                    exp_err = 1'b1;
                end else begin
                    r = exp_q.pop_front();
                    if (r.id == 0) begin exp_v0 = 1'b1; exp_d0 = r.data; end
                    else           begin exp_v1 = 1'b1; exp_d1 = r.data; end
                end
            end
            exp_en = g0 | g1;
            if (g0 | g1) begin
                exp_rw    = g1 ? req1_rw    : req0_rw;
                exp_addr  = g1 ? req1_addr  : req0_addr;
                exp_wdata = g1 ? req1_wdata : req0_wdata;
                if (exp_rw) ref_mem[exp_addr] = exp_wdata;
                else        exp_q.push_back('{id: (g1 ? 1 : 0), data: ref_mem[exp_addr]});
                last_win = g1 ? 1 : 0;
                if (g1) drop1 = 1'b1;
                else    drop0 = 1'b1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = 32'h11111111 * i;
            ctl_mem[i] = 32'h11111111 * i;
        end
        reset = 1'b1; dat_ready = 1'b0; memctrl_out_data = '0;
        req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = '0; req1_wdata = '0;
        force_err = 1'b0;
        p_req = 0; p_wr = 0; p_rdy = 0;
        model_reset();
        repeat (2) @(posedge clock);

        // Mixed traffic
        p_req = 50; p_wr = 30; p_rdy = 60;
        repeat (400) cycle(1'b0);
        // Slow controller: tag FIFO fills, reads stall while writes pass
        p_req = 100; p_wr = 15; p_rdy = 5;
        repeat (300) cycle(1'b0);
        // Back-to-back reads from both ports with simultaneous push/pop
        p_req = 100; p_wr = 0; p_rdy = 100;
        repeat (300) cycle(1'b0);
        // Mixed traffic with a bursty controller
        p_req = 80; p_wr = 40; p_rdy = 30;
        repeat (300) cycle(1'b0);
        // Drain everything
        p_req = 0; p_rdy = 100;
        repeat (30) cycle(1'b0);
        // Stray dat_ready with nothing outstanding
        force_err = 1'b1;
        cycle(1'b0);
        force_err = 1'b0;
        repeat (3) cycle(1'b0);
        // Reset with requests pending: grants forced low, all state cleared
        p_req = 100; p_wr = 50;
        cycle(1'b1);
        p_req = 0;
        repeat (3) cycle(1'b0);
        p_req = 60; p_wr = 30; p_rdy = 50;
        repeat (200) cycle(1'b0);
        p_req = 0; p_rdy = 100;
        repeat (20) cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares one `sram_controller` instance between the message loader (port 0) and the SHA-256 round engine (port 1). It accepts one access per cycle, issues it to the controller through registered `memctrl_*` outputs, and tags every read so that `dat_ready`/`memctrl_out_data` return to the requester that issued it. It sits between the requesters and `sram_controller`, with the message SRAM behind the controller.

## Interface
- `ADDR_WIDTH`, default 3: SRAM word address width.
- `DATA_WIDTH`, default 32: SRAM word width.
- `MAX_OUTSTANDING`, default 4: maximum reads issued but not yet returned; must be a power of two, ≥2.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `reqN_valid`  in  1  requester N (N = 0, 1) has an access pending; held until granted.
- `reqN_rw`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  ADDR_WIDTH  word address.
- `reqN_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `reqN_gnt`  out  1  combinational; access accepted this cycle.
- `rspN_valid`  out  1  read data for requester N valid, one-cycle pulse.
- `rspN_data`  out  DATA_WIDTH  read data.
- `memctrl_enable`, `memctrl_rw`, `memctrl_addr`, `memctrl_write_data`  out  1/1/ADDR_WIDTH/DATA_WIDTH  registered command to `sram_controller`.
- `dat_ready`  in  1  controller read-data strobe.
- `memctrl_out_data`  in  DATA_WIDTH  controller read data.
- `arb_err`  out  1  sticky protocol-error flag.

## Operation
- Eligibility: a requester is eligible when `reqN_valid`=1 and either it is a write, or `outstanding` < MAX_OUTSTANDING.
- Round-robin: if one requester is eligible, it wins. If both are eligible, the requester other than `last_winner` wins. `last_winner` updates only on a grant. Reset value is 1, so port 0 wins the first tie.
- At most one `reqN_gnt` is high per cycle. An ineligible requester waits with its request held and no grant.
- Grant in cycle N: the winner's rw/addr/wdata are registered onto `memctrl_*` with `memctrl_enable`=1 in cycle N+1. With no grant, `memctrl_enable`=0 and the other `memctrl_*` outputs hold their last values.
- Read grant: the winner's id is pushed into a tag FIFO of depth MAX_OUTSTANDING, and `outstanding` is incremented.
- `dat_ready`=1: the head tag is popped and `outstanding` is decremented. `memctrl_out_data` is registered into `rsp<tag>_data`, and `rsp<tag>_valid`=1 in the next cycle.
- Read grant and `dat_ready` in the same cycle: push and pop both occur and `outstanding` is unchanged. Eligibility is computed from the pre-edge count, so a full FIFO never grants a read, even when a pop occurs in the same cycle.
- Ordering: `sram_controller` returns reads in issue order, so the tag FIFO is strictly FIFO. Writes carry no tag and produce no response.
- Error: `dat_ready`=1 while `outstanding`=0 sets `arb_err`. The data is dropped and no `rspN_valid` is raised. `arb_err` clears only on reset.
- `outstanding` is (log2(MAX_OUTSTANDING)+1) bits wide. The FIFO pointers are log2(MAX_OUTSTANDING) bits wide and wrap modulo the depth.

## Timing
- Reset values:
  - outputs `memctrl_enable`, `memctrl_rw`, `rsp0_valid`, `rsp1_valid`, `arb_err`: 0
  - outputs `memctrl_addr`, `memctrl_write_data`, `rsp0_data`, `rsp1_data`: 0
  - internal state: `outstanding`=0, FIFO empty, `last_winner`=1
- `reqN_gnt` is combinational from `reqN_valid`, `reqN_rw`, `outstanding` and `last_winner`, and is forced to 0 while `reset`=1.
- Request-to-command latency is 1 cycle; sustained throughput is one access per cycle.
- Response latency is `dat_ready` + 1 cycle. Total read latency is the controller latency + 2.
- Reset mid-operation: all tags are discarded, and both the arbiter and `sram_controller` share `reset`. A `dat_ready` arriving after reset with `outstanding`=0 sets `arb_err`; the bench must not generate one.

## Configuration
- `SRAM_ARB_FIXED_PRIORITY_EN` defined: fixed priority. Port 0 always wins when eligible, and `last_winner` is not implemented.
- `SRAM_ARB_FIXED_PRIORITY_EN` undefined: round-robin as described under Operation. This is the default build.

## Test plan
- Single read: `req0` reads addr 1 (SRAM word 1 = 0x11111111) → `req0_gnt` in cycle N, `memctrl_enable`=1 with addr 1 in N+1, `rsp0_valid`=1 with 0x11111111 one cycle after `dat_ready`; `rsp1_valid` stays 0.
- Contention: both ports read continuously (port 0 addr 2, port 1 addr 3) → after reset, grants alternate 0,1,0,1. Each response goes to the correct port in issue order. Under `SRAM_ARB_FIXED_PRIORITY_EN`, port 1 is never granted.
- Write then read: `req1` writes 0x56789ABC to addr 3, then reads addr 3 → write issued with `memctrl_rw`=1 and no response; the read returns `rsp1_data`=0x56789ABC.
- Full FIFO: `dat_ready` held low, port 0 issues 4 reads → `outstanding`=4 and a 5th read gets no grant, while a port 1 write is still granted. After one `dat_ready`, the 5th read is granted the next cycle.
- Simultaneous push/pop: a read grant in the same cycle as `dat_ready` → `outstanding` unchanged and tags correctly routed. FIFO pointers wrap past index 3 over 10 consecutive reads.
- Error and reset: `dat_ready` pulsed with `outstanding`=0 → `arb_err`=1, no `rspN_valid`. A subsequent `reset`=1 for one cycle clears `arb_err`, and all outputs return to their reset values.
